// File: rtl/func_scan_ctrl_if.sv
// Bundle between the scan sequencer, the test/config logic and the function datapath.
interface func_scan_ctrl_if #(
    parameter int unsigned IN_W = 4
);
    localparam int unsigned N = 1 << IN_W;

    logic            start;
    logic            abort;
    logic [N-1:0]    expected;
    logic [IN_W-1:0] fn_in;
    logic            fn_f;
    logic            busy;
    logic            done;
    logic [N-1:0]    table_q;
    logic [IN_W:0]   ones;
    logic            pass;

    // Test/config side plus the function unit's output.
    modport master (
        output start, abort, expected, fn_f,
        input  fn_in, busy, done, table_q, ones, pass
    );

    // Sequencer side.
    modport slave (
        input  start, abort, expected, fn_f,
        output fn_in, busy, done, table_q, ones, pass
    );
endinterface

// File: rtl/func_scan_ctrl.sv
// Sweeps every input vector through a combinational function unit, records its truth table,
// counts minterms and compares the result against a golden table latched at start.
module func_scan_ctrl #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned SETTLE = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    func_scan_ctrl_if.slave bus
);
    localparam int unsigned N     = 1 << IN_W;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [IN_W-1:0] r_fn_in, w_fn_in_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [N-1:0]    r_table, w_table_d;
    logic [IN_W:0]   r_ones, w_ones_d;
    logic [N-1:0]    r_exp, w_exp_d;
    logic            r_pass, w_pass_d;

    // Next-state logic: accept start, hold each vector SETTLE cycles, sample, finish or abort.
    always_comb begin
        w_state_d = r_state;
        w_fn_in_d = r_fn_in;
        w_cnt_d   = r_cnt;
        w_table_d = r_table;
        w_ones_d  = r_ones;
        w_exp_d   = r_exp;
        w_pass_d  = r_pass;
        case (r_state)
            StIdle: begin
                // abort in the same cycle suppresses the start
                if (bus.start && !bus.abort) begin
                    w_state_d = StRun;
                    w_table_d = '0;
                    w_ones_d  = '0;
                    w_exp_d   = bus.expected;
                    w_fn_in_d = '0;
                    w_cnt_d   = CNT_W'(SETTLE - 1);
                    w_pass_d  = 1'b0;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    w_state_d = StIdle;
                    w_pass_d  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - 1'b1;
                end else begin
                    w_table_d[r_fn_in] = bus.fn_f;
                    w_ones_d           = r_ones + {{IN_W{1'b0}}, bus.fn_f};
                    if (r_fn_in == IN_W'(N - 1)) begin
                        w_state_d = StDone;
                        // compare includes the sample taken this cycle
                        w_pass_d  = (w_table_d == r_exp);
                    end else begin
                        w_fn_in_d = r_fn_in + 1'b1;
                        w_cnt_d   = CNT_W'(SETTLE - 1);
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_fn_in <= '0;
            r_cnt   <= '0;
            r_table <= '0;
            r_ones  <= '0;
            r_exp   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_fn_in <= w_fn_in_d;
            r_cnt   <= w_cnt_d;
            r_table <= w_table_d;
            r_ones  <= w_ones_d;
            r_exp   <= w_exp_d;
            r_pass  <= w_pass_d;
        end
    end

    assign bus.fn_in   = r_fn_in;
    assign bus.busy    = (r_state == StRun);
    assign bus.done    = (r_state == StDone);
    assign bus.table_q = r_table;
    assign bus.ones    = r_ones;
    assign bus.pass    = r_pass;
endmodule
